// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit rotation, per-frame shadow snapshot, registered outputs.
// Optional leading-zero blanking is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    hex_mode,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    tick;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_dec;
    logic [6:0]              seg_next;

    function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        // Decimal mode shows nothing for the letter codes.
        if (!hex && nib > 4'h9) begin
            s = 7'h00;
        end
        return s;
    endfunction

    assign tick       = (pre_cnt == PRE_LAST);
    assign frame_wrap = tick && (dig_idx == IDX_LAST);

    // Scan state: disabled display parks at digit 0 with a transparent shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt      <= '0;
            dig_idx      <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
        end else if (!en) begin
            pre_cnt      <= '0;
            dig_idx      <= '0;
            shadow_value <= value;
            shadow_dp    <= dp_in;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                dig_idx <= frame_wrap ? '0 : dig_idx + 1'b1;
            end
            if (frame_wrap) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
            end
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        an_next = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_idx == IDX_W'(k)) begin
                cur_nib    = shadow_value[4*k +: 4];
                cur_dp     = shadow_dp[k];
                an_next[k] = 1'b1;
            end
        end
        seg_dec = decode(cur_nib, hex_mode);
    end

`ifdef SEG7_LZ_BLANK_EN
    logic lz_all_zero;
    logic lz_cur;

    // Walk from the most significant digit down; a digit is blankable while everything above and including it is zero.
    always_comb begin
        lz_all_zero = 1'b1;
        lz_cur      = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_all_zero = lz_all_zero && (shadow_value[4*k +: 4] == 4'h0);
            if (dig_idx == IDX_W'(k)) begin
                lz_cur = lz_all_zero && (k != 0);
            end
        end
        seg_next = lz_cur ? 7'h00 : seg_dec;
    end
`else
    assign seg_next = seg_dec;
`endif

    // Output stage lags dig_idx by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= cur_dp;
            an         <= an_next;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle slots): vector table plus multi-cycle sequences.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        hex_mode = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .hex_mode(hex_mode), .value(value),
        .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h00;
`else
    localparam logic [6:0] LZ_SEG = 7'h7E;
`endif

    typedef struct {
        logic [15:0]     value;
        logic            hex;
        logic [3:0]      dp;
        logic [3:0][6:0] seg;  // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Four cycles of one digit slot, starting at a negedge where that digit is already shown.
    task automatic check_slot(input int d, input logic [6:0] s, input logic p, input bit chk_seg);
        logic [3:0] exp_an;
        exp_an = 4'b0001 << d;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("an d%0d c%0d", d, c), {28'd0, an}, {28'd0, exp_an});
            if (chk_seg) check($sformatf("seg d%0d c%0d", d, c), {25'd0, seg}, {25'd0, s});
            check($sformatf("dp d%0d c%0d", d, c), {31'd0, dp}, {31'd0, p});
            check($sformatf("frame_done d%0d c%0d", d, c), {31'd0, frame_done},
                  {31'd0, (d == 3 && c == 3)});
            @(negedge clk);
        end
    endtask

    task automatic check_off(input string name);
        check({name, " seg"}, {25'd0, seg}, 32'd0);
        check({name, " an"}, {28'd0, an}, 32'd0);
        check({name, " dp"}, {31'd0, dp}, 32'd0);
        check({name, " frame_done"}, {31'd0, frame_done}, 32'd0);
    endtask

    task automatic run_vec(input int i);
        en       = 1'b0;
        value    = tbl[i].value;
        hex_mode = tbl[i].hex;
        dp_in    = tbl[i].dp;
        @(negedge clk);
        check_off($sformatf("vec%0d off", i));
        en = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) check_slot(d, tbl[i].seg[d], tbl[i].dp[d], 1'b1);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 1'b0, 4'b0000, {7'h30, 7'h6D, 7'h79, 7'h33}};
        tbl[1] = '{16'hABCD, 1'b1, 4'b0010, {7'h77, 7'h1F, 7'h4E, 7'h3D}};
        tbl[2] = '{16'hABCD, 1'b0, 4'b1001, {7'h00, 7'h00, 7'h00, 7'h00}};
        tbl[3] = '{16'h0042, 1'b0, 4'b0000, {LZ_SEG, LZ_SEG, 7'h33, 7'h6D}};
        tbl[4] = '{16'h5678, 1'b1, 4'b0100, {7'h5B, 7'h5F, 7'h70, 7'h7F}};
        tbl[5] = '{16'h9EF0, 1'b1, 4'b0000, {7'h7B, 7'h4F, 7'h47, 7'h7E}};
        tbl[6] = '{16'h9EF0, 1'b0, 4'b1000, {7'h7B, 7'h00, 7'h00, 7'h7E}};

        // Reset state.
        repeat (2) @(negedge clk);
        check_off("reset");

        // Release with en=1: first frame shows the reset shadow, second frame the captured 1234.
        value = 16'h1234;
        hex_mode = 1'b0;
        en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) check_slot(d, 7'h00, 1'b0, 1'b0);
        check_slot(0, 7'h33, 1'b0, 1'b1);
        check_slot(1, 7'h79, 1'b0, 1'b1);
        check_slot(2, 7'h6D, 1'b0, 1'b1);
        check_slot(3, 7'h30, 1'b0, 1'b1);

        // Asynchronous reset while digit 2 is selected.
        for (int n = 0; n < 40; n++) begin
            if (an == 4'b0100) break;
            @(negedge clk);
        end
        check("wait an=0100", {28'd0, an}, 32'h4);
        #1 rst = 1'b1;
        #1 check_off("async rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_slot(0, 7'h00, 1'b0, 1'b0);
        check_slot(1, 7'h00, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Snapshot isolation: a value change mid-frame waits for the next frame.
        en = 1'b0;
        value = 16'h1111;
        hex_mode = 1'b0;
        dp_in = 4'b0000;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check_slot(0, 7'h30, 1'b0, 1'b1);
        value = 16'h2222;
        for (int d = 1; d < 4; d++) check_slot(d, 7'h30, 1'b0, 1'b1);
        check_slot(0, 7'h6D, 1'b0, 1'b1);
        check_slot(1, 7'h6D, 1'b0, 1'b1);

        // Disable mid-frame, then re-enable with a new value and a dp on digit 1.
        en = 1'b0;
        @(negedge clk);
        check_off("en drop");
        value = 16'h5A3C;
        hex_mode = 1'b1;
        dp_in = 4'b0010;
        @(negedge clk);
        check_off("en low");
        en = 1'b1;
        @(negedge clk);
        check_slot(0, 7'h4E, 1'b0, 1'b1);
        check_slot(1, 7'h79, 1'b1, 1'b1);
        check_slot(2, 7'h77, 1'b0, 1'b1);
        check_slot(3, 7'h5B, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
